// File: rtl/counter_gen.sv
// Runtime-configurable up/down timer with continuous or one-shot operation.
// Optional prescaler is enabled by defining COUNTER_PRESCALE_EN.
module counter_gen #(
  parameter int unsigned CW = 16,
  parameter int unsigned PW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic          i_start,
  input  logic          i_stop,
  input  logic [1:0]    i_mode,
  input  logic [CW-1:0] i_max,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
`ifdef COUNTER_PRESCALE_EN
  input  logic [PW-1:0] i_prescale,
`endif
  output logic [CW-1:0] o_count,
  output logic          o_tc,
  output logic          o_busy,
  output logic          o_done
);

  if (CW < 2 || PW < 1) begin : g_param_check
    $error("counter_gen: CW must be >= 2 and PW >= 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          tc_q, tc_d;
  logic [1:0]    mode_q, mode_d;
  logic          tick;

`ifdef COUNTER_PRESCALE_EN
  logic [PW-1:0] presc_q, presc_d;

  // >= keeps the prescaler bounded if i_prescale is lowered mid-run.
  always_comb begin
    presc_d = presc_q;
    tick    = 1'b0;
    if (i_stop || i_load || i_start) begin
      presc_d = '0;
    end else if (state_q == RUN && i_en) begin
      if (presc_q >= i_prescale) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) presc_q <= '0;
    else       presc_q <= presc_d;
  end
`else
  always_comb begin
    tick = (state_q == RUN) && i_en;
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      count_q <= '0;
      tc_q    <= 1'b0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      mode_q  <= mode_d;
    end
  end

  // Control priority: stop > load > start > tick.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    mode_d  = mode_q;
    if (i_stop) begin
      state_d = IDLE;
    end else if (i_load) begin
      count_d = i_load_val;
    end else if (i_start) begin
      mode_d  = i_mode;
      count_d = i_mode[0] ? i_max : '0;
      state_d = RUN;
    end else if (tick) begin
      if (!mode_q[0]) begin
        if (count_q >= i_max) begin
          tc_d = 1'b1;
          if (mode_q[1]) state_d = DONE;
          else           count_d = '0;
        end else begin
          count_d = count_q + CW'(1);
        end
      end else begin
        if (count_q == '0) begin
          tc_d = 1'b1;
          if (mode_q[1]) state_d = DONE;
          else           count_d = i_max;
        end else begin
          count_d = count_q - CW'(1);
        end
      end
    end
  end

  always_comb begin
    o_count = count_q;
    o_tc    = tc_q;
    o_busy  = (state_q == RUN);
    o_done  = (state_q == DONE);
  end

endmodule

// File: tb/tb_counter_gen.sv
// Scoreboard bench for counter_gen: directed stimulus pushes hand-computed
// expectations; a monitor pops and compares one entry per clock.
module tb_counter_gen;

  localparam int unsigned CW = 16;
  localparam int unsigned PW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [CW-1:0] max_v = '0;
  logic          load = 1'b0;
  logic [CW-1:0] load_val = '0;
`ifdef COUNTER_PRESCALE_EN
  logic [PW-1:0] prescale = '0;
`endif
  logic [CW-1:0] count;
  logic          tc, busy, done;

  counter_gen #(.CW(CW), .PW(PW)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_start    (start),
    .i_stop     (stop),
    .i_mode     (mode),
    .i_max      (max_v),
    .i_load     (load),
    .i_load_val (load_val),
`ifdef COUNTER_PRESCALE_EN
    .i_prescale (prescale),
`endif
    .o_count    (count),
    .o_tc       (tc),
    .o_busy     (busy),
    .o_done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic [CW-1:0] cnt;
    logic        tc;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   tag = 0;

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (count !== e.cnt || tc !== e.tc || busy !== e.busy || done !== e.done) begin
        errors++;
        $display("FAIL test%0d: got count=%0d tc=%b busy=%b done=%b, expected count=%0d tc=%b busy=%b done=%b",
                 e.tag, count, tc, busy, done, e.cnt, e.tc, e.busy, e.done);
      end
    end
  end

  // Caller sets inputs first; pulses are cleared after the edge.
  task automatic cyc(input int c, input bit t, input bit b, input bit d);
    exp_t e;
    e.tag = tag; e.cnt = CW'(c); e.tc = t; e.busy = b; e.done = d;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
    start = 1'b0;
    stop  = 1'b0;
    load  = 1'b0;
  endtask

  initial begin
    #2;
    // Reset state
    tag = 0;
    rst = 1'b1;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    rst = 1'b0;

    // Up continuous, max 3: period 4
    tag = 1;
    en = 1'b1; mode = 2'b00; max_v = 3; start = 1'b1;
    cyc(0, 0, 1, 0);
    cyc(1, 0, 1, 0); cyc(2, 0, 1, 0); cyc(3, 0, 1, 0); cyc(0, 1, 1, 0);
    cyc(1, 0, 1, 0); cyc(2, 0, 1, 0); cyc(3, 0, 1, 0); cyc(0, 1, 1, 0);

    // Down one-shot, max 5
    tag = 2;
    mode = 2'b11; max_v = 5; start = 1'b1;
    cyc(5, 0, 1, 0);
    mode = 2'b00;
    cyc(4, 0, 1, 0); cyc(3, 0, 1, 0); cyc(2, 0, 1, 0); cyc(1, 0, 1, 0); cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 1);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1);

    // Lower i_max below count mid-run
    tag = 3;
    mode = 2'b00; max_v = 10; start = 1'b1;
    cyc(0, 0, 1, 0);
    for (int i = 1; i <= 7; i++) cyc(i, 0, 1, 0);
    max_v = 4;
    cyc(0, 1, 1, 0);
    cyc(1, 0, 1, 0); cyc(2, 0, 1, 0); cyc(3, 0, 1, 0); cyc(4, 0, 1, 0); cyc(0, 1, 1, 0);

    // Stop beats load; then load alone in IDLE
    tag = 4;
    max_v = 10; start = 1'b1;
    cyc(0, 0, 1, 0);
    cyc(1, 0, 1, 0); cyc(2, 0, 1, 0);
    stop = 1'b1; load = 1'b1; load_val = 9;
    cyc(2, 0, 0, 0);
    load = 1'b1;
    cyc(9, 0, 0, 0);
    cyc(9, 0, 0, 0);

    // Enable pause, then mid-run reset
    tag = 5;
    max_v = 2; start = 1'b1;
    cyc(0, 0, 1, 0);
    cyc(1, 0, 1, 0);
    en = 1'b0;
    cyc(1, 0, 1, 0); cyc(1, 0, 1, 0); cyc(1, 0, 1, 0);
    en = 1'b1;
    cyc(2, 0, 1, 0); cyc(0, 1, 1, 0); cyc(1, 0, 1, 0);
    rst = 1'b1;
    cyc(0, 0, 0, 0);
    rst = 1'b0;
    cyc(0, 0, 0, 0);

    // Down continuous reload, restart from RUN, load mid-run above max
    tag = 7;
    mode = 2'b01; max_v = 2; start = 1'b1;
    cyc(2, 0, 1, 0);
    cyc(1, 0, 1, 0); cyc(0, 0, 1, 0); cyc(2, 1, 1, 0); cyc(1, 0, 1, 0);
    mode = 2'b00; start = 1'b1;
    cyc(0, 0, 1, 0);
    load = 1'b1; load_val = 5;
    cyc(5, 0, 1, 0);
    cyc(0, 1, 1, 0);
    cyc(1, 0, 1, 0);

    // i_max = 0: terminal on every tick
    tag = 8;
    max_v = 0; start = 1'b1;
    cyc(0, 0, 1, 0);
    cyc(0, 1, 1, 0); cyc(0, 1, 1, 0); cyc(0, 1, 1, 0);
    stop = 1'b1;
    cyc(0, 0, 0, 0);

`ifdef COUNTER_PRESCALE_EN
    // Prescaler 2, max 1: count steps every 3 cycles, tc every 6
    tag = 6;
    prescale = 2; max_v = 1; mode = 2'b00; start = 1'b1;
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0); cyc(0, 0, 1, 0); cyc(1, 0, 1, 0);
    cyc(1, 0, 1, 0); cyc(1, 0, 1, 0); cyc(0, 1, 1, 0);
    cyc(0, 0, 1, 0); cyc(0, 0, 1, 0); cyc(1, 0, 1, 0);
    cyc(1, 0, 1, 0); cyc(1, 0, 1, 0); cyc(0, 1, 1, 0);
    prescale = 0;
`endif

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
